// File: rtl/alu_sequencer.sv
// alu_sequencer: transactional front end for the registered ALU datapath.
// It takes one command per cmd handshake and drives the datapath select and
// enable lines over several cycles. It then returns the captured result and
// carry on the rsp handshake. Every output is a register, so each one already
// holds the value that belongs to the state being entered.

module alu_sequencer #(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic                 cmd_alu_sel,
    input  logic [BIT_WIDTH-1:0] cmd_opa,
    input  logic [BIT_WIDTH-1:0] cmd_opb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic [BIT_WIDTH-1:0] dp_in,
    output logic                 dp_s_reg,
    output logic                 dp_en_ra,
    output logic                 dp_en_rb,
    output logic                 dp_s,
    input  logic [BIT_WIDTH-1:0] dp_out,
    input  logic                 dp_cout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_EXEC   = 2'b00;
    localparam logic [1:0] OP_ACC    = 2'b01;
    localparam logic [1:0] OP_REPEAT = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    state_t               state;
    logic [1:0]           op_q;
    logic [BIT_WIDTH-1:0] opb_q;
    logic                 acc_ok;

    // Sequencer FSM with registered datapath controls and response outputs.
    // The feedback ops stay illegal until an EXEC completes, because the
    // datapath registers come out of reset holding unknown values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_EXEC;
            opb_q      <= '0;
            acc_ok     <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            dp_in      <= '0;
            dp_s_reg   <= 1'b1;
            dp_en_ra   <= 1'b0;
            dp_en_rb   <= 1'b0;
            dp_s       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        opb_q     <= cmd_opb;
                        dp_s      <= cmd_alu_sel;
                        cmd_ready <= 1'b0;
                        if (cmd_op == OP_RSVD || (cmd_op != OP_EXEC && !acc_ok)) begin
                            state      <= S_DONE;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_carry  <= 1'b0;
                        end else begin
                            state    <= S_LOAD_A;
                            dp_en_ra <= 1'b1;
                            if (cmd_op == OP_EXEC) begin
                                dp_s_reg <= 1'b1;
                                dp_in    <= cmd_opa;
                            end else begin
                                dp_s_reg <= 1'b0;
                                dp_in    <= '0;
                            end
                        end
                    end
                end
                S_LOAD_A: begin
                    dp_en_ra <= 1'b0;
                    dp_s_reg <= 1'b1;
                    if (op_q == OP_REPEAT) begin
                        state <= S_EXEC;
                        dp_in <= '0;
                    end else begin
                        state    <= S_LOAD_B;
                        dp_en_rb <= 1'b1;
                        dp_in    <= opb_q;
                    end
                end
                S_LOAD_B: begin
                    state    <= S_EXEC;
                    dp_en_rb <= 1'b0;
                    dp_in    <= '0;
                end
                S_EXEC: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state      <= S_DONE;
                    rsp_result <= dp_out;
                    rsp_carry  <= dp_cout;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    acc_ok     <= 1'b1;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    dp_en_ra  <= 1'b0;
                    dp_en_rb  <= 1'b0;
                    dp_s_reg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer connected to a behavioural model of
// the registered ALU datapath. Responses are compared against an
// operand-level reference model: directed cases first, then random commands.

module tb_alu_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic         cmd_alu_sel;
    logic [W-1:0] cmd_opa;
    logic [W-1:0] cmd_opb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_err;
    logic [W-1:0] dp_in;
    logic         dp_s_reg;
    logic         dp_en_ra;
    logic         dp_en_rb;
    logic         dp_s;
    logic [W-1:0] dp_out;
    logic         dp_cout;

    int checkCount = 0;
    int passCount  = 0;

    alu_sequencer #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_alu_sel(cmd_alu_sel),
        .cmd_opa    (cmd_opa),
        .cmd_opb    (cmd_opb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .dp_in      (dp_in),
        .dp_s_reg   (dp_s_reg),
        .dp_en_ra   (dp_en_ra),
        .dp_en_rb   (dp_en_rb),
        .dp_s       (dp_s),
        .dp_out     (dp_out),
        .dp_cout    (dp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: input mux, unreset operand registers, a combinational
    // ALU and a carry register that lags the ALU by one cycle.
    logic [W-1:0] regA, regB;
    logic         coutQ;
    logic [W:0]   aluFull;
    always_comb aluFull = dp_s ? ({1'b0, regA} - {1'b0, regB}) : ({1'b0, regA} + {1'b0, regB});
    assign dp_out  = aluFull[W-1:0];
    assign dp_cout = coutQ;
    always @(posedge clk) begin
        if (dp_en_ra) regA <= dp_s_reg ? dp_in : dp_out;
        if (dp_en_rb) regB <= dp_s_reg ? dp_in : dp_out;
        coutQ <= aluFull[W];
    end

    // Reference model state: the operands of the last completed operation,
    // plus whether any EXEC has completed since reset.
    int  modelA  = 0;
    int  modelB  = 0;
    bit  modelOk = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Issue one command, follow it to its response, and compare the result
    // with the reference model. The response is held for 'hold' cycles before
    // it is taken. While the sequencer is busy, junk commands are presented to
    // show that they are ignored.
    task automatic applyStimulus(input int op, input int sel, input int opa, input int opb,
                                 input int hold, input bit junk);
        int  a, b, full, expRes, expCarry, expErr, expLat, expRa, expRb, expSreg;
        int  cyc, raCnt, rbCnt, sregSeen, ainSeen, binSeen, busyReady, dsBad;
        logic [W-1:0] heldRes;

        expErr = (op == 3 || (op != 0 && !modelOk)) ? 1 : 0;
        if (op == 0) begin
            a = opa; b = opb;
        end else begin
            a = (sel != 0) ? ((modelA - modelB) & 15) : ((modelA + modelB) & 15);
            b = (op == 1) ? opb : modelB;
        end
        full     = (sel != 0) ? (a - b) : (a + b);
        expRes   = expErr ? 0 : (full & 15);
        expCarry = expErr ? 0 : ((sel != 0) ? int'(a < b) : int'(full > 15));
        // Edges after the accept edge until rsp_valid is seen; a rejected
        // command answers in the first cycle after it is accepted.
        expLat   = expErr ? 0 : ((op == 2) ? 3 : 4);
        expRa    = expErr ? 0 : 1;
        expRb    = (expErr || op == 2) ? 0 : 1;
        expSreg  = (op == 0) ? 1 : 0;

        checkOutput("cmd_ready_idle", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_op      = op[1:0];
        cmd_alu_sel = sel[0];
        cmd_opa     = opa[W-1:0];
        cmd_opb     = opb[W-1:0];
        @(negedge clk);
        cmd_valid = junk ? 1'b1 : 1'b0;
        cmd_op = 2'($urandom); cmd_alu_sel = ~sel[0];
        cmd_opa = W'($urandom); cmd_opb = W'($urandom);

        cyc = 0; raCnt = 0; rbCnt = 0; sregSeen = -1; ainSeen = -1; binSeen = -1;
        busyReady = 0; dsBad = 0;
        while (!rsp_valid && cyc < 20) begin
            if (dp_en_ra) begin raCnt++; sregSeen = dp_s_reg; ainSeen = dp_in; end
            if (dp_en_rb) begin rbCnt++; binSeen = dp_in; end
            if (cmd_ready) busyReady++;
            if (dp_s !== sel[0]) dsBad++;
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", cyc, expLat);
        checkOutput("en_ra_cycles", raCnt, expRa);
        checkOutput("en_rb_cycles", rbCnt, expRb);
        checkOutput("ready_while_busy", busyReady, 0);
        checkOutput("dp_s_held", dsBad, 0);
        if (expRa == 1) checkOutput("s_reg_load_a", sregSeen, expSreg);
        if (op == 0 && expErr == 0) checkOutput("dp_in_opa", ainSeen, opa);
        if (expRb == 1) checkOutput("dp_in_opb", binSeen, opb);
        checkOutput("rsp_err", rsp_err, expErr);
        checkOutput("rsp_result", rsp_result, expRes);
        checkOutput("rsp_carry", rsp_carry, expCarry);

        heldRes = rsp_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_ready", cmd_ready, 0);
            checkOutput("hold_result", rsp_result, heldRes);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", rsp_valid, 0);

        if (!expErr) begin
            modelA = a; modelB = b; modelOk = 1;
        end
    endtask

    initial begin
        cmd_valid = 0; cmd_op = 0; cmd_alu_sel = 0; cmd_opa = 0; cmd_opb = 0;
        rsp_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_enables", {dp_en_ra, dp_en_rb}, 0);
        checkOutput("rst_s_reg", dp_s_reg, 1);
        checkOutput("rst_dp_s_in", {dp_s, dp_in}, 0);
        checkOutput("rst_rsp_data", {rsp_err, rsp_carry, rsp_result}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequence: feedback rejected before any EXEC, then the
        // EXEC -> ACC -> REPEAT chain, then a subtract with back-pressure.
        applyStimulus(1, 0, 0, 3, 0, 0);
        applyStimulus(0, 0, 9, 8, 0, 0);
        applyStimulus(1, 0, 0, 3, 0, 0);
        applyStimulus(2, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 3, 5, 0);
        applyStimulus(3, 0, 1, 1, 1, 0);

        // Reset in the middle of an EXEC: everything drops at once, no
        // response, and feedback ops become illegal again.
        cmd_valid = 1; cmd_op = 0; cmd_alu_sel = 0; cmd_opa = 4'd6; cmd_opb = 4'd2;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        checkOutput("load_b_en", dp_en_rb, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_enables", {dp_en_ra, dp_en_rb}, 0);
        checkOutput("midrst_cmd_ready", cmd_ready, 1);
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelOk = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_no_rsp", rsp_valid, 0);
        end
        applyStimulus(1, 0, 0, 3, 0, 0);

        // Random commands against the reference model.
        for (int n = 0; n < 60; n++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
